register_bank_clr: RTL and testbench
====================================

# register_bank_clr

Parametrised successor to the single clear/preset register: a bank of `NrOfRegs` words of `NrOfBits` each. It provides one addressed write port and one registered read port. The read port drives a tri-stateable output bus. A bulk clear/preset sequencer sweeps the whole bank one entry per tick. It sits on the shared datapath bus alongside the existing register components and is advanced by the same `ClockEnable`/`Tick` gating.

## Interface

Parameters:
- `NrOfBits`, 8, word width (≥1).
- `NrOfRegs`, 16, number of entries (≥2).
- `AddrBits`, 4, address width; 2^`AddrBits` ≥ `NrOfRegs`.

Ports:
- `Clock`  in  1  single clock; all state changes on its rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `ClockEnable`  in  1  gates every state change.
- `Tick`  in  1  gates every state change; step = `ClockEnable & Tick`.
- `WrEn`  in  1  write request.
- `WrAddr`  in  `AddrBits`  write address.
- `D`  in  `NrOfBits`  write data.
- `RdEn`  in  1  read request.
- `RdAddr`  in  `AddrBits`  read address.
- `ClrAll`  in  1  start a bulk sweep that writes 0 to every entry.
- `PreAll`  in  1  start a bulk sweep that writes all-ones to every entry.
- `cs`  in  1  active-high output disable; `Q` is high-Z while `cs`=1.
- `Q`  out  `NrOfBits`  registered read data.
- `RdValid`  out  1  one-cycle pulse when `Q` has been updated by a read.
- `Busy`  out  1  high while a sweep is in progress.

## Operation

- Reset (`Reset`=0, asynchronous):
  - all entries = 0
  - Q register = 0
  - `RdValid` = 0, `Busy` = 0
  - state = IDLE, sweep index = 0
- Nothing changes on a clock edge without a step, except that `RdValid` deasserts.
- State machine:
  - IDLE:
    - On a step with `ClrAll` or `PreAll`: latch the fill value (`ClrAll` has priority, giving 0; otherwise all-ones), set index = 0, go to SWEEP.
    - On a step otherwise: perform the write if `WrEn`=1.
  - SWEEP:
    - Each step writes the fill value to entry[index] and increments the index.
    - The step that writes entry `NrOfRegs`-1 returns to IDLE and resets the index to 0.
    - `ClrAll`, `PreAll` and `WrEn` are ignored. The write is dropped, not queued.
- Write: entry[`WrAddr`] ← `D`. If `WrAddr` ≥ `NrOfRegs`, the write is ignored.
- A write requested in the same step as a sweep start is dropped.
- Read: this is allowed in both states.
  - On a step with `RdEn`=1, the Q register ← entry[`RdAddr`], or 0 if `RdAddr` ≥ `NrOfRegs`.
  - `RdValid` is 1 for exactly the following clock cycle.
  - `RdEn`=0 holds Q.
- Read of an address being written in the same step (by the write port or by the sweep): Q gets the pre-write contents, unless bypass is enabled (see Configuration).
- `Q` = `cs` ? all-Z : Q register. `cs` affects neither `RdValid` nor any internal state.
- `Busy` = (state == SWEEP), registered.

## Timing

- Write latency: the entry is updated at the edge of the write step. A read issued at the next step returns the new value.
- Read latency: 1 step. `Q` is valid after the edge of the `RdEn` step and stays stable until the next read step or reset.
- Sweep:
  - The start step sets `Busy`=1 at its edge.
  - A full sweep takes `NrOfRegs` further steps.
  - `Busy` falls at the edge of the step that writes the last entry.
  - A new start is accepted on the next step.
- Stalled steps (`Tick`=0 or `ClockEnable`=0) freeze the sweep index and state.
- Reset asserted mid-sweep:
  - The sweep aborts.
  - All entries are cleared, including those not yet swept.
  - The bank is in IDLE on release.
- `ClrAll` and `PreAll` together select clear.

## Configuration

- `REGBANK_BYPASS_EN` defined: read-during-write forwarding. When a read and a write (port or sweep) target the same in-range address in one step, Q captures the data being written (`D` or the fill value).
- Not defined: Q captures the old contents. No forwarding mux is built.

## Test plan

- Write 0xA5 to address 3, then read address 3 on the next step → `Q`=0xA5; `RdValid` high for one cycle; with `cs`=1, `Q`=Z.
- `PreAll` step with `NrOfRegs`=16 → `Busy`=1 for 16 steps; then reading every address returns 0xFF; writes attempted during the sweep leave no trace.
- Write 0x3C to address 5 and read address 5 in the same step → `Q`=old value (0x00) without `REGBANK_BYPASS_EN`, 0x3C with it.
- `WrAddr`=15 and `RdAddr`=14 with `NrOfRegs`=12 → no entry changes; `Q`=0x00.
- Fill the bank with 0xFF, start `ClrAll`, pull `Reset` low after 4 steps → `Busy`=0, all entries 0, `Q`=0, `RdValid`=0 immediately (asynchronously).
- `Tick`=0 for 3 cycles mid-sweep → index frozen; the sweep resumes and finishes after exactly `NrOfRegs` total steps.

Source files
------------

// File: rtl/register_bank_clr_if.sv
`default_nettype none
// ============================================================================
// Module      : register_bank_clr_if
// Description : Control, status and address/data bundle for register_bank_clr.
//               The tri-stated read bus Q is carried as a plain module port.
// Revision    : 1.0 - initial release
// ============================================================================
interface register_bank_clr_if #(
    parameter int NrOfBits = 8,
    parameter int AddrBits = 4
) ();
    logic                ClockEnable;
    logic                Tick;
    logic                WrEn;
    logic [AddrBits-1:0] WrAddr;
    logic [NrOfBits-1:0] D;
    logic                RdEn;
    logic [AddrBits-1:0] RdAddr;
    logic                ClrAll;
    logic                PreAll;
    logic                cs;
    logic                RdValid;
    logic                Busy;

    modport master (
        output ClockEnable, Tick, WrEn, WrAddr, D, RdEn, RdAddr, ClrAll, PreAll, cs,
        input  RdValid, Busy
    );

    modport slave (
        input  ClockEnable, Tick, WrEn, WrAddr, D, RdEn, RdAddr, ClrAll, PreAll, cs,
        output RdValid, Busy
    );
endinterface
`default_nettype wire

// File: rtl/register_bank_clr.sv
`default_nettype none
// ============================================================================
// Module      : register_bank_clr
// Description : Bank of NrOfRegs words with one write port, one registered
//               read port on a tri-stateable bus, and a bulk clear/preset
//               sweeper that visits one entry per step.
//               Optional macro REGBANK_BYPASS_EN: read-during-write forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module register_bank_clr #(
    parameter int NrOfBits = 8,
    parameter int NrOfRegs = 16,
    parameter int AddrBits = 4
) (
    input  wire                     Clock,
    input  wire                     Reset,
    register_bank_clr_if.slave      bus,
    output wire [NrOfBits-1:0]      Q
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    typedef logic [NrOfBits-1:0] word_t;

    state_t              state_q, state_d;
    logic [AddrBits-1:0] idx_q, idx_d;
    word_t               fill_q, fill_d;
    word_t               mem_q [NrOfRegs];
    word_t               mem_d [NrOfRegs];
    word_t               rd_q, rd_d;
    logic                rd_valid_q, rd_valid_d;
    logic                busy_q, busy_d;

    logic                w_step;
    logic                w_wr_en;
    logic [AddrBits-1:0] w_wr_addr;
    word_t               w_wr_data;
    logic                w_rd_in_range;

    assign w_step        = bus.ClockEnable & bus.Tick;
    assign w_rd_in_range = (32'(bus.RdAddr) < NrOfRegs);

    // Sequencer: choose the single write of this step (port or sweep) and the next state.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        fill_d    = fill_q;
        w_wr_en   = 1'b0;
        w_wr_addr = bus.WrAddr;
        w_wr_data = bus.D;
        if (w_step) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.ClrAll || bus.PreAll) begin
                        // Clear wins when both are requested; the port write is dropped.
                        fill_d  = bus.ClrAll ? '0 : '1;
                        idx_d   = '0;
                        state_d = ST_SWEEP;
                    end else if (bus.WrEn && (32'(bus.WrAddr) < NrOfRegs)) begin
                        w_wr_en = 1'b1;
                    end
                end
                ST_SWEEP: begin
                    w_wr_en   = 1'b1;
                    w_wr_addr = idx_q;
                    w_wr_data = fill_q;
                    if (32'(idx_q) == NrOfRegs - 1) begin
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + AddrBits'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
            endcase
        end
        busy_d = (state_d == ST_SWEEP);
    end

    // Storage update and read capture; reads see pre-write contents unless forwarding is built.
    always_comb begin
        mem_d      = mem_q;
        rd_d       = rd_q;
        rd_valid_d = 1'b0;
        if (w_step && bus.RdEn) begin
            rd_valid_d = 1'b1;
            if (w_rd_in_range) begin
                rd_d = mem_q[bus.RdAddr];
`ifdef REGBANK_BYPASS_EN
                if (w_wr_en && (w_wr_addr == bus.RdAddr)) begin
                    rd_d = w_wr_data;
                end
`endif
            end else begin
                rd_d = '0;
            end
        end
        if (w_wr_en) begin
            mem_d[w_wr_addr] = w_wr_data;
        end
    end

    // State, bank and read registers; reset clears every entry including unswept ones.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            fill_q     <= '0;
            mem_q      <= '{default: '0};
            rd_q       <= '0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            fill_q     <= fill_d;
            mem_q      <= mem_d;
            rd_q       <= rd_d;
            rd_valid_q <= rd_valid_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.RdValid = rd_valid_q;
    assign bus.Busy    = busy_q;
    assign Q           = bus.cs ? {NrOfBits{1'bz}} : rd_q;

endmodule
`default_nettype wire

// File: tb/tb_register_bank_clr.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_bank_clr
// Description : Self-checking bench for register_bank_clr (16-entry and
//               12-entry instances) with a behavioural bank model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_bank_clr;

    localparam int NB   = 8;
    localparam int NR   = 16;
    localparam int AB   = 4;
    localparam int NR12 = 12;
`ifdef REGBANK_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    register_bank_clr_if #(.NrOfBits(NB), .AddrBits(AB)) bus   ();
    register_bank_clr_if #(.NrOfBits(NB), .AddrBits(AB)) bus12 ();
    wire [NB-1:0] q_bus;
    wire [NB-1:0] q12_bus;

    register_bank_clr #(.NrOfBits(NB), .NrOfRegs(NR), .AddrBits(AB)) u_dut (
        .Clock (clk),
        .Reset (rst_n),
        .bus   (bus),
        .Q     (q_bus)
    );

    register_bank_clr #(.NrOfBits(NB), .NrOfRegs(NR12), .AddrBits(AB)) u_dut12 (
        .Clock (clk),
        .Reset (rst_n),
        .bus   (bus12),
        .Q     (q12_bus)
    );

    // Behavioural model: contents, read register, and sweep progress as plain variables.
    logic [NB-1:0] m_mem [NR];
    logic [NB-1:0] m_q;
    bit            m_valid;
    bit            m_sweeping;
    int            m_pos;
    logic [NB-1:0] m_fill;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit          wr;
        logic [3:0]  wa;
        logic [7:0]  d;
        bit          rd;
        logic [3:0]  ra;
        bit          tk;
        logic [7:0]  eq;
        bit          ev;
    } vec_t;
    vec_t tbl [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_mem[i] = '0;
        m_q        = '0;
        m_valid    = 1'b0;
        m_sweeping = 1'b0;
        m_pos      = 0;
        m_fill     = '0;
    endtask

    // One clock cycle on the 16-entry instance: drive, predict, clock, compare.
    task automatic cyc(input bit ce, input bit tk, input bit wr, input logic [3:0] wa,
                       input logic [7:0] d, input bit rd, input logic [3:0] ra,
                       input bit clr, input bit pre, input bit cs);
        bit            st;
        bit            did_wr;
        int            wa_i;
        logic [NB-1:0] wd;
        logic [NB-1:0] nq;
        bus.ClockEnable = ce;  bus.Tick = tk;
        bus.WrEn = wr; bus.WrAddr = wa; bus.D = d;
        bus.RdEn = rd; bus.RdAddr = ra;
        bus.ClrAll = clr; bus.PreAll = pre; bus.cs = cs;
        st     = ce & tk;
        did_wr = 1'b0;
        wa_i   = 0;
        wd     = '0;
        nq     = m_q;
        if (st && rd) nq = (int'(ra) < NR) ? m_mem[ra] : '0;
        if (st) begin
            if (!m_sweeping) begin
                if (clr || pre) begin
                    m_fill     = clr ? 8'h00 : 8'hFF;
                    m_sweeping = 1'b1;
                    m_pos      = 0;
                end else if (wr && int'(wa) < NR) begin
                    did_wr = 1'b1; wa_i = int'(wa); wd = d;
                end
            end else begin
                did_wr = 1'b1; wa_i = m_pos; wd = m_fill;
                m_pos++;
                if (m_pos == NR) begin
                    m_sweeping = 1'b0;
                    m_pos      = 0;
                end
            end
        end
        if (did_wr) begin
            if (BYP && st && rd && int'(ra) == wa_i) nq = wd;
            m_mem[wa_i] = wd;
        end
        m_q     = nq;
        m_valid = st && rd;
        @(posedge clk);
        #1;
        check("busy", 32'(bus.Busy), 32'(m_sweeping));
        check("rdvalid", 32'(bus.RdValid), 32'(m_valid));
        if (!cs) check("q", 32'(q_bus), 32'(m_q));
    endtask

    task automatic idle_bus();
        bus.ClockEnable = 1'b0; bus.Tick = 1'b0; bus.WrEn = 1'b0; bus.WrAddr = '0;
        bus.D = '0; bus.RdEn = 1'b0; bus.RdAddr = '0; bus.ClrAll = 1'b0;
        bus.PreAll = 1'b0; bus.cs = 1'b0;
    endtask

    task automatic rd12(input logic [3:0] ra, input logic [7:0] exp);
        bus12.WrEn = 1'b0; bus12.RdEn = 1'b1; bus12.RdAddr = ra;
        @(posedge clk);
        #1;
        check("r12_q", 32'(q12_bus), 32'(exp));
        check("r12_valid", 32'(bus12.RdValid), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int steps;
        idle_bus();
        bus12.ClockEnable = 1'b0; bus12.Tick = 1'b0; bus12.WrEn = 1'b0; bus12.WrAddr = '0;
        bus12.D = '0; bus12.RdEn = 1'b0; bus12.RdAddr = '0; bus12.ClrAll = 1'b0;
        bus12.PreAll = 1'b0; bus12.cs = 1'b0;
        model_reset();

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.Busy), 32'd0);
        check("rst_valid", 32'(bus.RdValid), 32'd0);
        check("rst_q", 32'(q_bus), 32'd0);
        rst_n = 1'b1;

        // 12-entry instance: out-of-range write/read, then last valid entry
        bus12.ClockEnable = 1'b1; bus12.Tick = 1'b1;
        bus12.WrEn = 1'b1; bus12.WrAddr = 4'd15; bus12.D = 8'h77;
        bus12.RdEn = 1'b1; bus12.RdAddr = 4'd14;
        @(posedge clk);
        #1;
        check("oor_q", 32'(q12_bus), 32'd0);
        check("oor_valid", 32'(bus12.RdValid), 32'd1);
        bus12.WrEn = 1'b1; bus12.WrAddr = 4'd11; bus12.D = 8'h5A; bus12.RdEn = 1'b0;
        @(posedge clk);
        #1;
        for (int a = 0; a < NR12; a++) rd12(4'(a), (a == 11) ? 8'h5A : 8'h00);
        rd12(4'd15, 8'h00);
        bus12.RdEn = 1'b0; bus12.ClockEnable = 1'b0;

        // Directed vector table on the 16-entry instance (bank is all zero here)
        tbl[0] = '{1'b1, 4'd3,  8'hA5, 1'b0, 4'd0,  1'b1, 8'h00, 1'b0};
        tbl[1] = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd3,  1'b1, 8'hA5, 1'b1};
        tbl[2] = '{1'b1, 4'd3,  8'h11, 1'b1, 4'd3,  1'b0, 8'hA5, 1'b0};
        tbl[3] = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd3,  1'b1, 8'hA5, 1'b1};
        tbl[4] = '{1'b1, 4'd5,  8'h3C, 1'b1, 4'd5,  1'b1, (BYP ? 8'h3C : 8'h00), 1'b1};
        tbl[5] = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd5,  1'b1, 8'h3C, 1'b1};
        tbl[6] = '{1'b1, 4'd15, 8'hFF, 1'b1, 4'd0,  1'b1, 8'h00, 1'b1};
        tbl[7] = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd15, 1'b1, 8'hFF, 1'b1};
        tbl[8] = '{1'b0, 4'd0,  8'h00, 1'b0, 4'd0,  1'b1, 8'hFF, 1'b0};
        for (int i = 0; i < 9; i++) begin
            cyc(1'b1, tbl[i].tk, tbl[i].wr, tbl[i].wa, tbl[i].d, tbl[i].rd, tbl[i].ra,
                1'b0, 1'b0, 1'b0);
            check("tbl_q", 32'(q_bus), 32'(tbl[i].eq));
            check("tbl_valid", 32'(bus.RdValid), 32'(tbl[i].ev));
        end

        // Output disable: bus released, internal read path keeps working
        cyc(1'b1, 1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        check("cs_release", 32'(q_bus !== 8'hA5), 32'd1);
        cyc(1'b1, 1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        check("cs_q_after", 32'(q_bus), 32'h3C);

        // Preset sweep with ignored writes/starts and a 3-cycle Tick stall
        cyc(1'b1, 1'b1, 1'b1, 4'd7, 8'h12, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        check("sweep_start_busy", 32'(bus.Busy), 32'd1);
        steps = 0;
        for (int k = 0; k < 100 && bus.Busy; k++) begin
            bit stall;
            stall = (k >= 5 && k < 8);
            cyc(1'b1, !stall, 1'b1, 4'($urandom), 8'($urandom), 1'b0, 4'd0,
                (k == 2), 1'b0, 1'b0);
            if (!stall) steps++;
        end
        check("sweep_steps", 32'(steps), 32'(NR));
        for (int a = 0; a < NR; a++) begin
            cyc(1'b1, 1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 4'(a), 1'b0, 1'b0, 1'b0);
            check("preset_rd", 32'(q_bus), 32'hFF);
        end

        // Clear sweep aborted by asynchronous reset after 4 steps
        cyc(1'b1, 1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 4'd9, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++)
            cyc(1'b1, 1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 4'(k + 10), 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(bus.Busy), 32'd0);
        check("arst_valid", 32'(bus.RdValid), 32'd0);
        check("arst_q", 32'(q_bus), 32'd0);
        model_reset();
        idle_bus();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int a = 0; a < NR; a++) begin
            cyc(1'b1, 1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 4'(a), 1'b0, 1'b0, 1'b0);
            check("arst_rd", 32'(q_bus), 32'd0);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            bit  r_clr, r_pre;
            int  sel;
            sel   = int'($urandom_range(0, 59));
            r_clr = (sel == 0) || (sel == 2);
            r_pre = (sel == 1) || (sel == 2);
            cyc(($urandom % 8) != 0, ($urandom % 6) != 0, $urandom_range(0, 1) == 1,
                4'($urandom), 8'($urandom), $urandom_range(0, 1) == 1, 4'($urandom),
                r_clr, r_pre, ($urandom % 8) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
